// File: rtl/priority_grant_arbiter_4_if.sv
// Request/grant bundle between four requesting agents and priority_grant_arbiter_4.
// The master side drives the requests; the slave side is the arbiter.
interface priority_grant_arbiter_4_if;
    logic       Request_0_In;
    logic       Request_1_In;
    logic       Request_2_In;
    logic       Request_3_In;
    logic       Grant_0_Out;
    logic       Grant_1_Out;
    logic       Grant_2_Out;
    logic       Grant_3_Out;
    logic       Grant_Valid_Out;
    logic [1:0] Grant_Index_Out;
    logic       Timeout_Out;

    modport master (
        output Request_0_In, Request_1_In, Request_2_In, Request_3_In,
        input  Grant_0_Out, Grant_1_Out, Grant_2_Out, Grant_3_Out,
        input  Grant_Valid_Out, Grant_Index_Out, Timeout_Out
    );

    modport slave (
        input  Request_0_In, Request_1_In, Request_2_In, Request_3_In,
        output Grant_0_Out, Grant_1_Out, Grant_2_Out, Grant_3_Out,
        output Grant_Valid_Out, Grant_Index_Out, Timeout_Out
    );
endinterface

// File: rtl/priority_grant_arbiter_4.sv
// Four-requester hold-until-release arbiter with forced revoke after MAX_HOLD_CYCLES.
// Define ROUND_ROBIN_EN for rotating priority; the default is fixed priority 0 > 1 > 2 > 3.
module priority_grant_arbiter_4 #(
    parameter int MAX_HOLD_CYCLES = 16
) (
    input logic Clock_In,
    input logic Reset_In,
    priority_grant_arbiter_4_if.slave bus
);
    localparam int COUNT_WIDTH = $clog2(MAX_HOLD_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] HOLD_LIMIT = COUNT_WIDTH'(MAX_HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                 state;
    logic [3:0]             grant;
    logic [3:0]             mask;
    logic [1:0]             grant_index;
    logic                   grant_valid;
    logic                   timeout;
    logic [COUNT_WIDTH-1:0] hold_count;

    logic [3:0] request;
    logic [3:0] candidates;
    logic       any_candidate;
    logic [1:0] winner;
    logic       holder_request;
    logic       others_waiting;

`ifdef ROUND_ROBIN_EN
    logic [1:0] rr_ptr;

    // Search starts at the pointer; the smallest rotational offset wins.
    function automatic logic [1:0] pick_rotating(input logic [3:0] req, input logic [1:0] start);
        logic [1:0] idx;
        pick_rotating = start;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (req[idx]) pick_rotating = idx;
        end
    endfunction
`else
    function automatic logic [1:0] pick_fixed(input logic [3:0] req);
        pick_fixed = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) pick_fixed = 2'(i);
        end
    endfunction
`endif

    assign request = {bus.Request_3_In, bus.Request_2_In, bus.Request_1_In, bus.Request_0_In};

    // Only the revoked requester is excluded, and only for the dead cycle that follows the revoke.
    always_comb begin
        candidates = request;
        if (state == GAP) candidates = request & ~mask;
    end

    assign any_candidate  = |candidates;
    assign holder_request = request[grant_index];
    assign others_waiting = |(request & ~grant);

`ifdef ROUND_ROBIN_EN
    assign winner = pick_rotating(candidates, rr_ptr);
`else
    assign winner = pick_fixed(candidates);
`endif

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state       <= IDLE;
            grant       <= 4'b0000;
            mask        <= 4'b0000;
            grant_index <= 2'b00;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            hold_count  <= '0;
`ifdef ROUND_ROBIN_EN
            rr_ptr      <= 2'b00;
`endif
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE, GAP: begin
                    mask <= 4'b0000;
                    if (any_candidate) begin
                        state       <= GRANT;
                        grant       <= 4'b0001 << winner;
                        grant_index <= winner;
                        grant_valid <= 1'b1;
                        hold_count  <= COUNT_WIDTH'(1);
`ifdef ROUND_ROBIN_EN
                        rr_ptr      <= winner + 2'd1;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (!holder_request) begin
                        state       <= GAP;
                        grant       <= 4'b0000;
                        grant_index <= 2'b00;
                        grant_valid <= 1'b0;
                    end else if (hold_count == HOLD_LIMIT && others_waiting) begin
                        state       <= GAP;
                        mask        <= grant;
                        timeout     <= 1'b1;
                        grant       <= 4'b0000;
                        grant_index <= 2'b00;
                        grant_valid <= 1'b0;
                    end else if (hold_count != HOLD_LIMIT) begin
                        // A lone holder parks at the limit instead of wrapping.
                        hold_count <= hold_count + 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant       <= 4'b0000;
                    grant_index <= 2'b00;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Grant_0_Out     = grant[0];
    assign bus.Grant_1_Out     = grant[1];
    assign bus.Grant_2_Out     = grant[2];
    assign bus.Grant_3_Out     = grant[3];
    assign bus.Grant_Valid_Out = grant_valid;
    assign bus.Grant_Index_Out = grant_index;
    assign bus.Timeout_Out     = timeout;
endmodule

// File: tb/tb_priority_grant_arbiter_4.sv
// Randomized and directed bench for priority_grant_arbiter_4 with MAX_HOLD_CYCLES = 4,
// compared cycle by cycle against a behavioural arbiter model.
module tb_priority_grant_arbiter_4;
    localparam int MAXH = 4;

    logic clk;
    logic rst;
    int   checkCount;
    int   errorCount;

    // Reference model: who holds, how long, whether a dead cycle is pending and who is barred.
    int mHolder;
    int mHeld;
    bit mInGap;
    int mBarred;
    bit mTimeout;
    int mPtr;

    priority_grant_arbiter_4_if arbBus ();

    priority_grant_arbiter_4 #(.MAX_HOLD_CYCLES(MAXH)) dut (
        .Clock_In(clk),
        .Reset_In(rst),
        .bus(arbBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock edge of the reference arbiter, evaluated with the requests seen at that edge.
    task automatic modelStep(input logic [3:0] req, input logic rstNow);
        bit others;
        int w;
        int idx;
        int start;
        if (rstNow) begin
            mHolder = -1; mHeld = 0; mInGap = 0; mBarred = -1; mTimeout = 0; mPtr = 0;
        end else if (mHolder >= 0) begin
            mTimeout = 0;
            others = 0;
            for (int i = 0; i < 4; i++) if (i != mHolder && req[i]) others = 1;
            if (!req[mHolder]) begin
                mHolder = -1;
                mInGap = 1;
            end else if (mHeld == MAXH && others) begin
                mBarred = mHolder;
                mHolder = -1;
                mInGap = 1;
                mTimeout = 1;
            end else if (mHeld < MAXH) begin
                mHeld++;
            end
        end else begin
            mTimeout = 0;
`ifdef ROUND_ROBIN_EN
            start = mPtr;
`else
            start = 0;
`endif
            w = -1;
            for (int k = 0; k < 4; k++) begin
                idx = (start + k) % 4;
                if (w < 0 && req[idx] && !(mInGap && idx == mBarred)) w = idx;
            end
            mInGap = 0;
            mBarred = -1;
            if (w >= 0) begin
                mHolder = w;
                mHeld = 1;
                mPtr = (w + 1) % 4;
            end
        end
    endtask

    task automatic compareAll();
        logic [3:0] expGrant;
        logic [3:0] obsGrant;
        expGrant = 4'b0000;
        if (mHolder >= 0) expGrant[mHolder] = 1'b1;
        obsGrant = {arbBus.Grant_3_Out, arbBus.Grant_2_Out, arbBus.Grant_1_Out, arbBus.Grant_0_Out};
        checkOutput("grant", 32'(obsGrant), 32'(expGrant));
        checkOutput("valid", 32'(arbBus.Grant_Valid_Out), 32'(mHolder >= 0));
        checkOutput("index", 32'(arbBus.Grant_Index_Out), (mHolder >= 0) ? 32'(mHolder) : 32'd0);
        checkOutput("timeout", 32'(arbBus.Timeout_Out), 32'(mTimeout));
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic rstNow);
        arbBus.Request_0_In = req[0];
        arbBus.Request_1_In = req[1];
        arbBus.Request_2_In = req[2];
        arbBus.Request_3_In = req[3];
        rst = rstNow;
        @(posedge clk);
        modelStep(req, rstNow);
        #1;
        compareAll();
    endtask

    initial begin
        int cnt;
        int toCount;
        int nGrants;
        bit prevValid;
        logic [3:0] reqs;
        int expOrder[5];
        checkCount = 0;
        errorCount = 0;
        mHolder = -1; mHeld = 0; mInGap = 0; mBarred = -1; mTimeout = 0; mPtr = 0;

        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0000, 1'b1);

        // Reset in the middle of a grant, request still present afterwards.
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("reset_grant_clear", 32'(arbBus.Grant_2_Out), 32'd0);
        applyStimulus(4'b0100, 1'b0);
        checkOutput("after_reset_index", 32'(arbBus.Grant_Index_Out), 32'd2);
        applyStimulus(4'b0000, 1'b1);

        // Simultaneous 1 and 3: 1 wins, release gives a gap then 3.
        applyStimulus(4'b1010, 1'b0);
        checkOutput("simul_winner", 32'(arbBus.Grant_1_Out), 32'd1);
        applyStimulus(4'b1000, 1'b0);
        checkOutput("simul_gap", 32'(arbBus.Grant_Valid_Out), 32'd0);
        applyStimulus(4'b1000, 1'b0);
        checkOutput("simul_second", 32'(arbBus.Grant_3_Out), 32'd1);
        applyStimulus(4'b0000, 1'b1);

        // Forced revoke: 0 and 2 held continuously.
        cnt = 0; toCount = 0;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(4'b0101, 1'b0);
            if (toCount == 0 && arbBus.Grant_0_Out) cnt++;
            if (arbBus.Timeout_Out) toCount++;
        end
        checkOutput("revoke_len", 32'(cnt), 32'd4);
        checkOutput("revoke_pulses", 32'(toCount), 32'd1);
        checkOutput("revoke_next", 32'(arbBus.Grant_2_Out), 32'd1);
        applyStimulus(4'b0000, 1'b1);

        // Lone requester is never revoked.
        applyStimulus(4'b1000, 1'b0);
        cnt = 0; toCount = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'b1000, 1'b0);
            if (arbBus.Grant_3_Out) cnt++;
            if (arbBus.Timeout_Out) toCount++;
        end
        checkOutput("lone_hold", 32'(cnt), 32'd20);
        checkOutput("lone_timeouts", 32'(toCount), 32'd0);
        applyStimulus(4'b0000, 1'b1);

        // Holder releases exactly in its final permitted cycle.
        for (int i = 0; i < 4; i++) applyStimulus(4'b0011, 1'b0);
        applyStimulus(4'b0010, 1'b0);
        checkOutput("release_no_timeout", 32'(arbBus.Timeout_Out), 32'd0);
        applyStimulus(4'b0010, 1'b0);
        checkOutput("release_next", 32'(arbBus.Grant_1_Out), 32'd1);
        applyStimulus(4'b0000, 1'b1);

        // Everyone requests; each holder releases after two cycles and re-requests at once.
`ifdef ROUND_ROBIN_EN
        expOrder = '{0, 1, 2, 3, 0};
`else
        expOrder = '{0, 0, 0, 0, 0};
`endif
        reqs = 4'b1111; nGrants = 0; prevValid = 1'b0;
        for (int i = 0; i < 40 && nGrants < 5; i++) begin
            applyStimulus(reqs, 1'b0);
            if (arbBus.Grant_Valid_Out && !prevValid) begin
                checkOutput($sformatf("order_%0d", nGrants), 32'(arbBus.Grant_Index_Out), 32'(expOrder[nGrants]));
                nGrants++;
            end
            prevValid = arbBus.Grant_Valid_Out;
            reqs = 4'b1111;
            if (mHolder >= 0 && mHeld == 2) reqs[mHolder] = 1'b0;
        end
        checkOutput("order_count", 32'(nGrants), 32'd5);
        applyStimulus(4'b0000, 1'b1);

        // Random traffic: requests toggle occasionally so grants are held for a while.
        reqs = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) reqs[b] = ~reqs[b];
            applyStimulus(reqs, ($urandom_range(0, 199) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule

// File: doc/priority_grant_arbiter_4.md
# priority_grant_arbiter_4

Four-requester arbiter that shares one downstream resource, such as a bus or datapath port, among requesters 0–3. It chooses among them using the same lowest-index-wins priority as the team's 4-2 priority encoders. The winner holds a registered one-hot grant until it drops its request, or until a hold-time limit forces a revoke because other requesters are waiting. It sits between the requesting agents and the shared resource; `Grant_Index_Out` can drive the resource's select mux directly.

## Interface
- `MAX_HOLD_CYCLES`, default 16: maximum consecutive grant cycles before a forced revoke when others are waiting; legal range 2..255.
- `Clock_In`  input  1  single clock, rising edge.
- `Reset_In`  input  1  reset, synchronous, active-high.
- `Request_0_In` .. `Request_3_In`  input  1 each  level request; held high for as long as the resource is needed.
- `Grant_0_Out` .. `Grant_3_Out`  output  1 each  registered one-hot grant.
- `Grant_Valid_Out`  output  1  high when any grant is asserted.
- `Grant_Index_Out`  output  2  index of the current grant holder; 2'b00 when `Grant_Valid_Out` = 0.
- `Timeout_Out`  output  1  one-cycle pulse on a forced revoke.

## Operation
- **States:**
  - `IDLE`: no grant.
  - `GRANT`: one grant is asserted.
  - `GAP`: one dead cycle with no grant.
- **IDLE:**
  - Any request → `GRANT` to the arbitration winner; the hold counter loads 1.
  - No request → stay in `IDLE`.
- **GRANT, checked in this order:**
  - Holder's request low → `GAP`.
  - Else, hold counter == `MAX_HOLD_CYCLES` and any other request high → `GAP`, pulse `Timeout_Out`, and set the mask bit for the revoked index.
  - Else stay in `GRANT`; the hold counter increments and saturates at `MAX_HOLD_CYCLES`.
- **GAP:** grants are all 0.
  - Any unmasked request → `GRANT` to the winner among unmasked requests; the counter loads 1.
  - No unmasked request → `IDLE`.
  - The mask clears on leaving `GAP`.
- **Arbitration (default):** fixed priority, 0 > 1 > 2 > 3.
- **Grant encoding:** exactly one `Grant_n_Out` is high in `GRANT`, none in `IDLE` or `GAP`. `Grant_Index_Out` equals the one-hot position encoded.
- **Hold counter:** width is the bits needed for `MAX_HOLD_CYCLES`. It never wraps.
- **Sole requester:** a lone requester is never revoked; the counter saturates and the grant holds indefinitely.
- **Holder drops request in the timeout cycle:** treated as a normal release. No `Timeout_Out` pulse, no mask set.
- **Reset (any state, including mid-grant):**
  - Next edge: state `IDLE`, all grants 0, `Grant_Valid_Out` 0, `Grant_Index_Out` 2'b00, `Timeout_Out` 0, counter 0, mask 0, round-robin pointer 0.
  - Requests present during reset are evaluated on the first edge after `Reset_In` falls.

## Timing
- **Grant latency:**
  - Request rises before edge k while in `IDLE` → grant high after edge k (1 cycle).
  - From `GAP`, the same 1-cycle latency applies.
- **Release:**
  - Request falls before edge k → grant low after edge k.
  - The next grant, if any, is high after edge k+1. The one-cycle `GAP` is guaranteed between any two grants.
- **Forced revoke:** with `MAX_HOLD_CYCLES` = N, the grant is high for exactly N cycles. `Timeout_Out` is high for the single `GAP` cycle.
- **Registered outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.
- **Simultaneous requests:** requests arriving in the same cycle are resolved by the priority rule. A request arriving during `GRANT` waits; it does not pre-empt the holder.

## Configuration
- **`ROUND_ROBIN_EN` undefined:** fixed priority 0 > 1 > 2 > 3. The masking in `GAP` is the only fairness mechanism.
- **`ROUND_ROBIN_EN` defined:**
  - Arbitration starts at pointer P and searches P, P+1, ... modulo 4.
  - On every grant, P ← granted index + 1 (mod 4; 3 wraps to 0). P resets to 0.
  - Masking in `GAP` still applies.

## Test plan
- **Reset mid-grant:** Request_2 high and granted; assert `Reset_In` for one cycle → all grants 0 after that edge. After reset falls with Request_2 still high → `Grant_2_Out` high one cycle later, `Grant_Index_Out` = 2'b10.
- **Simultaneous request, fixed priority:** requests 1 and 3 rise together in `IDLE` → `Grant_1_Out` after 1 cycle. Drop Request_1 → one `GAP` cycle, then `Grant_3_Out`.
- **Forced revoke:** `MAX_HOLD_CYCLES` = 4; Request_0 and Request_2 held continuously → `Grant_0_Out` for exactly 4 cycles, `Timeout_Out` pulse in `GAP`, then `Grant_2_Out` (Request_0 masked).
- **Lone requester:** `MAX_HOLD_CYCLES` = 4; only Request_3 held for 20 cycles → `Grant_3_Out` high all 20 cycles; `Timeout_Out` never pulses.
- **Release in the timeout cycle:** Request_0 drops exactly in its 4th grant cycle while Request_1 is waiting → `GAP` with `Timeout_Out` = 0, then `Grant_1_Out`.
- **Round-robin (`ROUND_ROBIN_EN` defined):** all four requests held; each holder releases after 2 cycles and re-requests immediately → grant order 0, 1, 2, 3, 0 (pointer wrap-around).
